// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// master drives start and operands; slave returns status and result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving an external 1-bit full-adder cell,
// LSB first, with held sum, carry-out and signed overflow.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_co
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cmsb;
    logic             cout_q;
    logic             ovf_q;
    logic             last;
    logic             pre;

    assign last    = (count == CW'(WIDTH - 1));
    assign pre     = (count == CW'(WIDTH - 2));
    // sum_sh keeps only the upper bits; the new bit enters at the MSB
    assign sum_nxt = {fa_s, sum_sh};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fa_x      = 1'b0;
        fa_y      = 1'b0;
        fa_cin    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                fa_x   = a_sh[0];
                fa_y   = b_sh[0];
                fa_cin = carry;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cmsb   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        count  <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    count  <= count + 1'b1;
                    // carry out of bit WIDTH-2 is the carry into the MSB
                    if (pre) cmsb <= fa_co;
                    if (last) begin
                        sum_q  <= sum_nxt;
                        cout_q <= fa_co;
                        ovf_q  <= cmsb ^ fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural full-adder cell.
// Accepted starts push expected results; done pulses pop and compare.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst;
    logic fa_x, fa_y, fa_cin, fa_s, fa_co;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W), .CW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .fa_x   (fa_x),
        .fa_y   (fa_y),
        .fa_cin (fa_cin),
        .fa_s   (fa_s),
        .fa_co  (fa_co)
    );

    assign fa_s  = fa_x ^ fa_y ^ fa_cin;
    assign fa_co = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int accepts = 0;
    int dones = 0;
    logic [W+1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] u;
        int s;
        logic ov;
        u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        s  = int'($signed(x)) + int'($signed(y)) + int'(c);
        ov = (s > 127) || (s < -128);
        return {ov, u};
    endfunction

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && bus.done) begin
            dones++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", {24'h0, bus.sum}, {24'h0, e[W-1:0]});
                chk("cout", {31'h0, bus.cout}, {31'h0, e[W]});
                chk("ovf", {31'h0, bus.ovf}, {31'h0, e[W+1]});
            end
        end
        if (!rst && bus.start && !bus.busy) begin
            sb.push_back(model(bus.a, bus.b, bus.cin));
            accepts++;
        end
    end

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, output int bc,
                          output logic [W-1:0] xs, output int dpos);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = ic;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~ia;
        bus.b     = ~ib;
        bus.cin   = ~ic;
        bc   = 0;
        xs   = '0;
        dpos = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            if (bus.done) dpos = bc;
            else if (bc < W) xs[bc] = fa_x;
            bc++;
        end
        if (bus.busy) chk("timeout", 1, 0);
    endtask

    initial begin
        int bc, dpos, a0;
        logic [W-1:0] xs;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 0);
        chk("rst_done", {31'h0, bus.done}, 0);
        chk("rst_sum", {24'h0, bus.sum}, 0);
        chk("rst_fa", {29'h0, fa_x, fa_y, fa_cin}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, bc, xs, dpos);
        chk("fa_x_seq", {24'h0, xs}, 32'h05);
        chk("busy_cycles", bc, 9);
        chk("done_pos", dpos, 8);
        chk("held_sum", {24'h0, bus.sum}, 32'h08);

        run_op(8'hFF, 8'h01, 1'b0, bc, xs, dpos);
        run_op(8'h7F, 8'h01, 1'b0, bc, xs, dpos);
        chk("ovf_7f", {31'h0, bus.ovf}, 1);
        run_op(8'h80, 8'h80, 1'b1, bc, xs, dpos);
        chk("cout_80", {31'h0, bus.cout}, 1);
        run_op(8'h80, 8'h80, 1'b0, bc, xs, dpos);
        chk("sum_80", {24'h0, bus.sum}, 0);

        // continuous start with changing operands
        a0 = accepts;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.a   = 8'($urandom);
            bus.b   = 8'($urandom);
            bus.cin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        chk("hold_accepts", accepts - a0, 4);
        for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
        chk("hold_drain", {31'h0, bus.busy}, 0);

        // mid-run reset
        run_op(8'h12, 8'h34, 1'b0, bc, xs, dpos);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        accepts = accepts - sb.size();
        sb.delete();
        chk("mr_busy", {31'h0, bus.busy}, 0);
        chk("mr_done", {31'h0, bus.done}, 0);
        chk("mr_sum", {24'h0, bus.sum}, 0);
        chk("mr_cout_ovf", {30'h0, bus.cout, bus.ovf}, 0);
        chk("mr_fa", {29'h0, fa_x, fa_y, fa_cin}, 0);
        run_op(8'hAA, 8'h55, 1'b0, bc, xs, dpos);
        chk("mr_after_sum", {24'h0, bus.sum}, 32'hFF);
        chk("mr_after_cout", {31'h0, bus.cout}, 0);

        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(8'($urandom), 8'($urandom), 1'($urandom), bc, xs, dpos);
        end

        repeat (3) @(negedge clk);
        chk("done_per_start", dones, accepts);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial sequencer wrapped around the team's 1-bit full-adder cell (x, y, Cin -> s, Co).
- Accepts two WIDTH-bit operands and a carry-in through a start/busy/done handshake.
- Each cycle it presents one operand bit pair, LSB first, plus the registered carry to the cell, then shifts the cell's sum bit into a result register.
- Produces the WIDTH-bit sum, carry-out and signed overflow for the board display/LED stage downstream.

Parameters:
WIDTH, 8, operand/sum width in bits (legal 2..32)
CW, 6, counter width; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
fa_x  output  1  bit to full-adder x
fa_y  output  1  bit to full-adder y
fa_cin  output  1  carry to full-adder Cin
fa_s  input  1  full-adder s
fa_co  input  1  full-adder Co
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  registered result, held until next accepted start
cout  output  1  final carry-out, held
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB), held

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge, any state, including mid-RUN):
  - state<=IDLE; count<=0; shift regs and carry<=0.
  - sum<=0, cout<=0, ovf<=0, done<=0, busy<=0.
  - Reset overrides start in the same cycle.
- States are IDLE, RUN and DONE.
- IDLE:
  - fa_x=fa_y=fa_cin=0.
  - start=1 -> a_sh<=a, b_sh<=b, carry<=cin, count<=0, sum_sh<=0, state<=RUN.
  - sum/cout/ovf keep their previous values until the first RUN update.
- RUN:
  - Combinational outputs: fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry.
  - Each edge:
    - sum_sh<={fa_s, sum_sh[WIDTH-1:1]}
    - a_sh, b_sh shift right by 1 (zero fill)
    - carry<=fa_co
    - count<=count+1
  - When count==WIDTH-2 at the edge, also record cmsb<=fa_co (carry into MSB).
  - When count==WIDTH-1, the edge does the last shift and:
    - sum<={fa_s, sum_sh[WIDTH-1:1]}
    - cout<=fa_co
    - ovf<=cmsb^fa_co
    - done<=1
    - state<=DONE
- DONE: lasts exactly one cycle; done=1, busy=1; next edge -> IDLE with done<=0.
- start handling: start is ignored in RUN and DONE; no queuing.
- Latency:
  - Accepting edge = edge 0.
  - done is high in the cycle after edge WIDTH+1 edges... precisely: done asserted for the cycle between edges WIDTH and WIDTH+1.
  - busy is high from edge 0 to edge WIDTH+1, i.e. WIDTH+1 cycles.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- Arithmetic:
  - Unsigned modulo 2^WIDTH sum.
  - cout = bit WIDTH of a+b+cin.
  - ovf is the two's-complement overflow.
- Cell assumption: the full adder is purely combinational; its outputs are sampled in the same cycle the fa_* outputs are driven. No cell latency is tolerated.
- Held outputs: sum/cout/ovf update only at the final RUN edge and are stable otherwise. A reset mid-operation clears them; no partial result is ever published.
- The operand inputs a, b and cin may change freely after acceptance.

Test Plan:
- WIDTH=8: a=8'h05, b=8'h03, cin=0, start one cycle -> fa_x sequence 1,0,1,0,0,0,0,0; done pulses after 8 RUN cycles; sum=8'h08, cout=0, ovf=0; busy high 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- a=8'h80, b=8'h80, cin=1 -> sum=8'h01, cout=1, ovf=1; same operands with cin=0 -> sum=8'h00.
- Hold start high continuously with changing a/b -> operations accepted only in IDLE, every 10 cycles; each result matches the operands present at its accepting edge.
- Assert rst at the 4th RUN cycle of an 8'hAA+8'h55 operation -> next cycle: busy=0, done=0, sum=0, cout=0, ovf=0, fa_*=0; a fresh start then completes normally (8'hFF, cout 0).
- Random regression: 1000 random a, b, cin with random idle gaps -> {cout,sum}==a+b+cin, ovf matches the sign rule, exactly one done pulse per accepted start.
